pc_unit: RTL
============

Name: pc_unit

Overview:
- Parametrised program-counter block for the KGP RISC fetch stage.
- Holds the fetch PC and selects the next PC from:
  - sequential increment
  - relative branch
  - absolute jump
  - call/return via an optional return-address stack (RAS)
  - stall or halt
- Drives the instruction-memory address and a one-cycle redirect pulse used to flush fetch/decode.

Parameters:
- PC_W, 8, PC width in bits.
- OFF_W, 8, signed branch-offset width (OFF_W <= PC_W).
- STEP, 1, sequential increment in address units.
- RESET_VEC, 0, PC value after reset.
- RAS_DEPTH, 4, return-address-stack entries (power of 2, >= 2); used only with PC_RAS_EN.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC (pipeline bubble).
- halt_req  in  1  enter HALTED.
- resume  in  1  leave HALTED.
- jump_valid  in  1  absolute transfer to jump_target.
- jump_target  in  PC_W  absolute target.
- call  in  1  qualifies jump_valid as a call (push return address).
- ret  in  1  return.
- branch_valid  in  1  taken relative branch.
- branch_offset  in  OFF_W  signed offset, two's complement.
- pc  out  PC_W  current fetch address (registered).
- link_addr  out  PC_W  return address captured on the last call (registered).
- redirect  out  1  one-cycle pulse on the cycle after any taken transfer.
- halted  out  1  high in the HALTED state.
- ras_overflow  out  1  sticky; push while the RAS was full.
- ras_underflow  out  1  sticky; pop while the RAS was empty.

Behaviour:
- Reset (rst=1 at posedge):
  - pc=RESET_VEC, link_addr=0, redirect=0, halted=0.
  - RAS emptied; both sticky flags cleared; state=RUN.
  - rst overrides every other input, including mid-halt.
- States are RUN and HALTED.
  - RUN -> HALTED: halt_req=1.
  - HALTED -> RUN: resume=1 and halt_req=0.
  - In HALTED, pc holds, transfers are ignored and redirect=0.
- Next-PC selection in RUN, priority high to low:
  1. halt_req: pc holds.
  2. ret: pc = popped RAS entry.
  3. jump_valid: pc = jump_target. If call=1, also push pc+STEP and set link_addr=pc+STEP.
  4. branch_valid: pc = pc + sign_extend(branch_offset).
  5. stall: pc holds.
  6. Otherwise: pc = pc+STEP.
- A transfer (items 2-4) wins over stall, because the redirect flushes the stalled slot.
- call without jump_valid is ignored.
- Width rules:
  - All additions are modulo 2^PC_W; wrap-around is silent (0xFF+1 -> 0x00 for PC_W=8).
  - branch_offset is sign-extended to PC_W before the add.
- redirect=1 in the cycle after any taken ret, jump or branch; 0 otherwise, including after a stall.
- Latency: the selected PC is visible on pc one cycle after the inputs are sampled.
- RAS full + push: the oldest entry is overwritten (circular); ras_overflow is set and held.
- RAS empty + ret: pc = pc+STEP, redirect=0, ras_underflow is set and held.
- Same-cycle call (jump_valid+call) and ret: ret wins. The push is dropped, there is no RAS change beyond the pop, and link_addr is unchanged.

Optional Feature:
- Macro: PC_RAS_EN.
- Defined:
  - RAS of RAS_DEPTH entries, PC_W wide, with a log2(RAS_DEPTH)+1-bit occupancy count.
  - Push/pop behave as above; the sticky flags are live.
- Undefined:
  - No RAS storage.
  - ret redirects to link_addr, with redirect asserted.
  - call still captures link_addr.
  - ras_overflow and ras_underflow are tied to 0.

Decomposition:
- Shared package kgp_pc_pkg holds:
  - state encoding constants (ST_RUN=0, ST_HALTED=1)
  - a next-PC select enum: SEL_HOLD, SEL_INC, SEL_BR, SEL_JMP, SEL_RET
- One natural sub-module: pc_ras (circular stack: push, pop, top, full, empty, overflow/underflow), instantiated only under PC_RAS_EN.

Test Plan:
- Reset, then 3 cycles with no inputs -> pc 0x00,0x01,0x02,0x03. Set RESET_VEC=0x10 -> first pc 0x10.
- pc=0xFE, two idle cycles -> 0xFF then 0x00 (wrap). pc=0x05, branch_offset=0xFB (-5) -> pc=0x00, redirect=1 the next cycle.
- pc=0x20, jump_valid+call, target 0x80 -> pc=0x80, link_addr=0x21. Later ret -> pc=0x21, redirect=1.
- RAS_DEPTH=4: 5 nested calls -> ras_overflow=1. 5 rets -> the first 4 return correctly, the 5th gives pc+1 and ras_underflow=1.
- stall held 3 cycles at pc=0x40 -> pc stays 0x40. stall+branch_valid(+4) -> pc=0x44.
- halt_req at pc=0x30 -> halted=1, pc stays 0x30 despite jump_valid. resume -> pc=0x31. rst while halted -> pc=RESET_VEC, halted=0.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// Shared types for the KGP fetch-stage program counter: FSM states and next-PC select codes.
package kgp_pc_pkg;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } pc_state_e;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_INC,
    SEL_BR,
    SEL_JMP,
    SEL_RET
  } pc_sel_e;

  // Any selection that leaves the sequential stream flushes fetch/decode.
  function automatic logic is_transfer(pc_sel_e sel);
    return (sel == SEL_BR) || (sel == SEL_JMP) || (sel == SEL_RET);
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Control/transfer bundle between the pipeline controller (master) and pc_unit (slave).
interface pc_unit_if #(
  parameter int PC_W  = 8,
  parameter int OFF_W = 8
) ();
  logic             stall;
  logic             halt_req;
  logic             resume;
  logic             jump_valid;
  logic [PC_W-1:0]  jump_target;
  logic             call;
  logic             ret;
  logic             branch_valid;
  logic [OFF_W-1:0] branch_offset;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  link_addr;
  logic             redirect;
  logic             halted;
  logic             ras_overflow;
  logic             ras_underflow;

  modport master (
    output stall, halt_req, resume, jump_valid, jump_target, call, ret,
           branch_valid, branch_offset,
    input  pc, link_addr, redirect, halted, ras_overflow, ras_underflow
  );

  modport slave (
    input  stall, halt_req, resume, jump_valid, jump_target, call, ret,
           branch_valid, branch_offset,
    output pc, link_addr, redirect, halted, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/pc_unit_ras.sv
// Circular return-address stack; a push while full overwrites the oldest entry.
module pc_ras #(
  parameter int PC_W  = 8,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic [PC_W-1:0] i_data,
  output logic [PC_W-1:0] o_top,
  output logic            o_empty,
  output logic            o_overflow,
  output logic            o_underflow
);
  localparam int AW = $clog2(DEPTH);

  logic [PC_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_ptr;
  logic [AW:0]     r_cnt;
  logic            r_ovf;
  logic            r_unf;
  logic            w_full;
  logic [AW-1:0]   w_top_idx;

  assign w_full    = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign w_top_idx = r_ptr - AW'(1);
  assign o_top     = r_mem[w_top_idx];
  assign o_overflow  = r_ovf;
  assign o_underflow = r_unf;

  // r_ptr is the next write slot; when full it also points at the oldest entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (i_push) begin
      r_ptr <= r_ptr + AW'(1);
      if (w_full) r_ovf <= 1'b1;
      else        r_cnt <= r_cnt + (AW+1)'(1);
    end else if (i_pop) begin
      if (o_empty) begin
        r_unf <= 1'b1;
      end else begin
        r_ptr <= w_top_idx;
        r_cnt <= r_cnt - (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_ptr] <= i_data;
  end

endmodule

// File: rtl/pc_unit.sv
// KGP fetch program counter: next-PC select, RUN/HALTED FSM, redirect pulse.
// Build with PC_RAS_EN defined to add a hardware return-address stack (pc_ras).
module pc_unit
  import kgp_pc_pkg::*;
#(
  parameter int PC_W      = 8,
  parameter int OFF_W     = 8,
  parameter int STEP      = 1,
  parameter int RESET_VEC = 0,
  parameter int RAS_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  pc_unit_if.slave   bus
);

  if (OFF_W > PC_W || RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_param_err
    $error("pc_unit: illegal parameter combination");
  end

  logic [PC_W-1:0]         r_pc;
  logic [PC_W-1:0]         r_link;
  logic                    r_redirect;
  pc_state_e               r_state;
  pc_state_e               w_state_nxt;
  pc_sel_e                 w_sel;
  logic [PC_W-1:0]         w_pc_nxt;
  logic [PC_W-1:0]         w_pc_inc;
  logic [PC_W-1:0]         w_br_tgt;
  logic [PC_W-1:0]         w_ret_tgt;
  logic signed [OFF_W-1:0] w_off;
  logic signed [PC_W-1:0]  w_off_ext;
  logic                    w_ras_empty;

  assign w_off     = bus.branch_offset;
  assign w_off_ext = PC_W'(w_off);
  assign w_pc_inc  = r_pc + PC_W'(STEP);
  assign w_br_tgt  = r_pc + w_off_ext;

`ifdef PC_RAS_EN
  logic w_push;
  logic w_pop;

  // A ret in the same cycle outranks the call, so the push is dropped there.
  assign w_push = (w_sel == SEL_JMP) && bus.call;
  assign w_pop  = (r_state == ST_RUN) && !bus.halt_req && bus.ret;

  pc_ras #(
    .PC_W  (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_data      (w_pc_inc),
    .o_top       (w_ret_tgt),
    .o_empty     (w_ras_empty),
    .o_overflow  (bus.ras_overflow),
    .o_underflow (bus.ras_underflow)
  );
`else
  assign w_ras_empty       = 1'b0;
  assign w_ret_tgt         = r_link;
  assign bus.ras_overflow  = 1'b0;
  assign bus.ras_underflow = 1'b0;
`endif

  always_comb begin
    w_sel       = SEL_INC;
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      ST_RUN: begin
        if (bus.halt_req) begin
          w_sel       = SEL_HOLD;
          w_state_nxt = ST_HALTED;
        end else if (bus.ret) begin
          w_sel = w_ras_empty ? SEL_INC : SEL_RET;
        end else if (bus.jump_valid) begin
          w_sel = SEL_JMP;
        end else if (bus.branch_valid) begin
          w_sel = SEL_BR;
        end else if (bus.stall) begin
          w_sel = SEL_HOLD;
        end
      end
      default: begin
        w_sel = SEL_HOLD;
        if (bus.resume && !bus.halt_req) w_state_nxt = ST_RUN;
      end
    endcase
    case (w_sel)
      SEL_INC: w_pc_nxt = w_pc_inc;
      SEL_BR:  w_pc_nxt = w_br_tgt;
      SEL_JMP: w_pc_nxt = bus.jump_target;
      SEL_RET: w_pc_nxt = w_ret_tgt;
      default: w_pc_nxt = r_pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= PC_W'(RESET_VEC);
      r_link     <= '0;
      r_redirect <= 1'b0;
      r_state    <= ST_RUN;
    end else begin
      r_pc       <= w_pc_nxt;
      r_state    <= w_state_nxt;
      r_redirect <= is_transfer(w_sel);
      if ((w_sel == SEL_JMP) && bus.call) r_link <= w_pc_inc;
    end
  end

  assign bus.pc        = r_pc;
  assign bus.link_addr = r_link;
  assign bus.redirect  = r_redirect;
  assign bus.halted    = (r_state == ST_HALTED);

endmodule
